// File: rtl/dtc_rr_scheduler_if.sv
// Bundle of the request, classifier and response signals of the
// round-robin classifier scheduler. The slave modport faces the scheduler and
// the master modport faces the producers, the classifier and the consumer.
interface dtc_rr_scheduler_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*9-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [8:0]        cls_inp;
  logic [8:0]        cls_outp;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [8:0]        rsp_class;
  logic [3:0]        rsp_level;
  logic              rsp_err;
  logic [CNTW-1:0]   done_cnt;

  modport slave (
    input  req_valid, req_data, cls_outp, rsp_ready,
    output req_ready, cls_inp, rsp_valid, rsp_id, rsp_class, rsp_level,
           rsp_err, done_cnt
  );

  modport master (
    output req_valid, req_data, cls_outp, rsp_ready,
    input  req_ready, cls_inp, rsp_valid, rsp_id, rsp_class, rsp_level,
           rsp_err, done_cnt
  );
endinterface

// File: rtl/dtc_rr_scheduler.sv
// Round-robin scheduler sharing one combinational decision-tree classifier
// between NREQ requesters. Stage 1 registers the selected feature vector onto
// cls_inp; stage 2 captures the classifier result with id, level and an
// integrity flag, under valid/ready backpressure.
module dtc_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input logic               clk,
  input logic               rst_n,
  dtc_rr_scheduler_if.slave bus
);

  logic            s1_valid;
  logic [IDW-1:0]  s1_id;
  logic [8:0]      cls_inp_q;
  logic [IDW-1:0]  rr_ptr;
  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [8:0]      rsp_class_q;
  logic [3:0]      rsp_level_q;
  logic            rsp_err_q;
  logic [CNTW-1:0] done_cnt_q;

  logic            rsp_free;
  logic            s1_adv;
  logic            s1_free;
  logic            rsp_hs;
  logic            accept;
  logic            gnt_found;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW-1:0]  nxt_ptr;
  logic [IDW:0]    scan_idx;
  logic [NREQ-1:0] ready;
  logic [8:0]      feat [NREQ];
  logic [3:0]      pop;
  logic            code_err;

  assign rsp_free = !rsp_valid_q || bus.rsp_ready;
  assign s1_adv   = s1_valid && rsp_free;
  assign s1_free  = !s1_valid || s1_adv;
  assign rsp_hs   = rsp_valid_q && bus.rsp_ready;
  assign accept   = s1_free && gnt_found;
  assign nxt_ptr  = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);

  // Scan requesters from rr_ptr upward, wrapping at NREQ; first valid wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (scan_idx >= (IDW+1)'(NREQ)) scan_idx = scan_idx - (IDW+1)'(NREQ);
      if (!gnt_found && bus.req_valid[scan_idx[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx[IDW-1:0];
      end
    end
  end

  // One-hot grant, only offered when stage 1 can take a new vector.
  always_comb begin
    ready = '0;
    if (accept) ready[gnt_idx] = 1'b1;
  end

  // Split the flat request bus into per-requester feature vectors.
  always_comb begin
    for (int i = 0; i < NREQ; i++) feat[i] = bus.req_data[9*i +: 9];
  end

  // Level and thermometer legality of the live classifier result.
  always_comb begin
    pop = '0;
    for (int i = 0; i < 9; i++) pop = pop + 4'(bus.cls_outp[i]);
    code_err = |(bus.cls_outp & (bus.cls_outp + 9'd1));
  end

  // Stage 1: latch the granted vector; cls_inp keeps its last value when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_id     <= '0;
      cls_inp_q <= '0;
      rr_ptr    <= '0;
    end else if (accept) begin
      s1_valid  <= 1'b1;
      s1_id     <= gnt_idx;
      cls_inp_q <= feat[gnt_idx];
      rr_ptr    <= nxt_ptr;
    end else if (s1_adv) begin
      s1_valid  <= 1'b0;
    end
  end

  // Stage 2: capture the classifier result; fields hold while not reloaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_class_q <= '0;
      rsp_level_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (s1_adv) begin
      rsp_valid_q <= 1'b1;
      rsp_id_q    <= s1_id;
      rsp_class_q <= bus.cls_outp;
      rsp_level_q <= pop;
      rsp_err_q   <= code_err;
    end else if (rsp_hs) begin
      rsp_valid_q <= 1'b0;
    end
  end

  // Saturating count of delivered responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_cnt_q <= '0;
    else if (rsp_hs && (done_cnt_q != '1)) done_cnt_q <= done_cnt_q + CNTW'(1);
  end

  assign bus.req_ready = ready;
  assign bus.cls_inp   = cls_inp_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_class = rsp_class_q;
  assign bus.rsp_level = rsp_level_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.done_cnt  = done_cnt_q;

endmodule

// File: doc/dtc_rr_scheduler.md
Name: dtc_rr_scheduler

Overview:
- Shares one combinational 9-in/9-out decision-tree classifier instance between NREQ requesters.
- Round-robin arbitration selects one feature vector per cycle and drives it to the classifier from a register.
- The thermometer-coded class result is captured into a response register with valid/ready backpressure.
- The response carries requester id, raw class code, decoded level and a code-integrity flag.
- Sits between feature producers and the downstream vote/aggregation logic; the classifier core itself is instantiated outside this block.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester id width; must satisfy 2**IDW >= NREQ.
- CNTW, 16, width of the completed-response counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_data  input  NREQ*9  feature vectors; requester i uses bits [9i+8:9i].
- req_ready  output  NREQ  one-hot grant / accept; combinational from req_valid and internal state.
- cls_inp  output  9  registered feature vector to the classifier.
- cls_outp  input  9  classifier result, combinational from cls_inp.
- rsp_valid  output  1  response register holds a result.
- rsp_ready  input  1  downstream accepts the response.
- rsp_id  output  IDW  requester index of the response.
- rsp_class  output  9  raw thermometer code captured from cls_outp.
- rsp_level  output  4  number of ones in rsp_class (0..9).
- rsp_err  output  1  rsp_class is not a legal thermometer code.
- done_cnt  output  CNTW  saturating count of response handshakes.

Behaviour:
- Reset, asynchronous on rst_n low: s1_valid=0, rsp_valid=0, rr_ptr=0, cls_inp=0, rsp_id=0, rsp_class=0, rsp_level=0, rsp_err=0, done_cnt=0.
- A reset mid-operation flushes all in-flight work. No response is emitted for requests accepted before reset.
- Two-stage pipeline:
  - S1: register cls_inp and s1_id, with valid bit s1_valid.
  - S2: the response register.
- Stall/advance conditions:
  - rsp_free = !rsp_valid || rsp_ready.
  - s1_adv = s1_valid && rsp_free.
  - s1_free = !s1_valid || s1_adv.
- Arbitration, only while s1_free:
  - Scan req_valid starting at index rr_ptr, ascending, wrapping at NREQ.
  - The first set bit i gets req_ready[i]=1; all other req_ready bits are 0.
  - When !s1_free or no request is pending, req_ready=0.
- On acceptance of i:
  - cls_inp <= req_data slice i; s1_id <= i; s1_valid <= 1.
  - rr_ptr <= (i+1) mod NREQ.
- When nothing is accepted: rr_ptr holds. If s1_adv, s1_valid <= 0. cls_inp holds its last value (no forced zero).
- On s1_adv:
  - rsp_class <= cls_outp; rsp_id <= s1_id; rsp_valid <= 1.
  - rsp_level <= popcount(cls_outp).
  - rsp_err <= ((cls_outp & (cls_outp + 1)) != 0), computed in 9 bits.
  - Legal codes are 0 or ones contiguous from bit 0. For example, 9'b000011111 is legal; 9'b000010111 sets rsp_err=1.
  - rsp_level is popcount even when rsp_err=1.
- Response handshake (rsp_valid && rsp_ready) without a new s1_adv: rsp_valid <= 0. Data fields hold their values.
- Response handshake and s1_adv in the same cycle: the new result is loaded and rsp_valid stays 1.
- Latency: accept at edge N gives rsp_valid=1 after edge N+1 (cls_inp valid after edge N).
- Throughput: one result per cycle with rsp_ready held high.
- Backpressure:
  - rsp_valid=1 and rsp_ready=0: S1 stalls and holds cls_inp.
  - If S1 is also full, req_ready=0.
  - rsp_* fields are stable while rsp_valid && !rsp_ready.
- done_cnt increments on each response handshake and saturates at all-ones.
- A requester deasserting req_valid without being granted is legal; the grant simply skips it.

Test Plan:
- Reset, then stub cls_outp = thermometer of inp[3:0] (capped at 9). Requester 0 only, req_data=9'h005, rsp_ready=1 → req_ready=4'b0001 at cycle 0; cls_inp=9'h005 at cycle 1; at cycle 2 rsp_valid=1, rsp_id=0, rsp_class=9'b000011111, rsp_level=5, rsp_err=0; done_cnt=1 after handshake.
- All four requesters valid continuously, rsp_ready=1 → grants in order 0,1,2,3,0,1; one response per cycle; rsp_id sequence 0,1,2,3,0,1.
- rr_ptr=2 with requesters 0 and 3 valid → requester 3 granted first, then 0; rr_ptr ends at 1.
- Back-to-back stream with rsp_ready=0 for 3 cycles → S1 and S2 fill and req_ready=0; rsp fields stay constant; on release, two responses arrive on consecutive cycles with no loss or duplication.
- Stub returns 9'b000010111 → rsp_err=1, rsp_level=4. Stub returns 9'b111111111 → rsp_err=0, rsp_level=9.
- Assert rst_n=0 with S1 and S2 full → all outputs zero immediately; after release no stale response appears. With done_cnt preset near 2**CNTW-1, done_cnt saturates at all-ones.
